id_ex_stage: RTL and testbench

ID/EX pipeline boundary of the 8-bit pipelined core, with load-use hazard detection and bubble insertion. It captures decoded operands and control from ID every cycle and presents the EX_* fields consumed by the EX-stage ALU and the operand forwarding unit. It also stalls PC and IF/ID on load-use, flushes on taken branches, and freezes on memory hold.

---
 rtl/cpu_pkg.sv | 29 ++
 rtl/load_use_detect.sv | 24 ++
 rtl/id_ex_stage.sv | 127 ++++++++++++
 tb/tb_id_ex_stage.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit pipelined core: widths, the non-writable
// register, ALU operation encodings and the per-stage control bundle.
package cpu_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 8;

  localparam logic [4:0] ZERO_REG = 5'd31;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_SLT = 3'd5;
  localparam logic [2:0] ALU_SLL = 3'd6;
  localparam logic [2:0] ALU_SRL = 3'd7;

  // Control bits that travel with an instruction through ID/EX, EX/MEM and MEM/WB.
  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic [2:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard equation: the load in EX targets a register the ID instruction reads.
// Purely combinational; a load into the non-writable register never stalls.
module load_use_detect #(
  parameter int REG_W = 5
) (
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             id_valid,
  output logic             hazard
);
  import cpu_pkg::*;

  logic rt_is_zero;
  logic src_match;

  assign rt_is_zero = (ex_rt == REG_W'(ZERO_REG));
  assign src_match  = (ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt));
  assign hazard     = ex_valid & ex_mem_read & ~rt_is_zero & src_match & id_valid;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, branch flush and memory-hold freeze.
// One cycle ID->EX latency; hold freezes everything, flush/load-use insert a counted bubble.
module id_ex_stage #(
  parameter int DATA_W = 8,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_W-1:0]  ID_rs,
  input  logic [REG_W-1:0]  ID_rt,
  input  logic [REG_W-1:0]  ID_rd,
  input  logic              ID_uses_rt,
  input  logic [DATA_W-1:0] ID_data1,
  input  logic [DATA_W-1:0] ID_data2,
  input  logic [DATA_W-1:0] ID_imm,
  input  logic              ID_RegWrite,
  input  logic              ID_MemRead,
  input  logic              ID_MemWrite,
  input  logic              ID_MemToReg,
  input  logic              ID_ALUSrc,
  input  logic [2:0]        ID_ALUOp,
  input  logic              ID_valid,
  input  logic              flush,
  input  logic              hold,
  output logic [REG_W-1:0]  EX_rs,
  output logic [REG_W-1:0]  EX_rt,
  output logic [REG_W-1:0]  EX_rd,
  output logic [DATA_W-1:0] EX_data1,
  output logic [DATA_W-1:0] EX_data2,
  output logic [DATA_W-1:0] EX_imm,
  output logic              EX_RegWrite,
  output logic              EX_MemRead,
  output logic              EX_MemWrite,
  output logic              EX_MemToReg,
  output logic              EX_ALUSrc,
  output logic [2:0]        EX_ALUOp,
  output logic              EX_valid,
  output logic              PC_write,
  output logic              IFID_write,
  output logic              load_use,
  output logic [7:0]        bubble_count
);
  import cpu_pkg::*;

  ctrl_t id_ctrl;
  ctrl_t ex_ctrl;
  logic  insert_bubble;

  assign id_ctrl = '{reg_write:  ID_RegWrite,
                     mem_read:   ID_MemRead,
                     mem_write:  ID_MemWrite,
                     mem_to_reg: ID_MemToReg,
                     alu_src:    ID_ALUSrc,
                     alu_op:     ID_ALUOp};

  assign EX_RegWrite = ex_ctrl.reg_write;
  assign EX_MemRead  = ex_ctrl.mem_read;
  assign EX_MemWrite = ex_ctrl.mem_write;
  assign EX_MemToReg = ex_ctrl.mem_to_reg;
  assign EX_ALUSrc   = ex_ctrl.alu_src;
  assign EX_ALUOp    = ex_ctrl.alu_op;

  load_use_detect #(.REG_W(REG_W)) u_load_use_detect (
    .ex_valid    (EX_valid),
    .ex_mem_read (EX_MemRead),
    .ex_rt       (EX_rt),
    .id_rs       (ID_rs),
    .id_rt       (ID_rt),
    .id_uses_rt  (ID_uses_rt),
    .id_valid    (ID_valid),
    .hazard      (load_use)
  );

  // Flush outranks the hazard: the stalled instruction is being squashed anyway.
  always_comb begin
    PC_write   = 1'b1;
    IFID_write = 1'b1;
    if (hold) begin
      PC_write   = 1'b0;
      IFID_write = 1'b0;
    end else if (!flush && load_use) begin
      PC_write   = 1'b0;
      IFID_write = 1'b0;
    end
  end

  assign insert_bubble = flush | load_use;

  always_ff @(posedge clk) begin
    if (rst) begin
      EX_rs        <= '0;
      EX_rt        <= '0;
      EX_rd        <= '0;
      EX_data1     <= '0;
      EX_data2     <= '0;
      EX_imm       <= '0;
      ex_ctrl      <= '0;
      EX_valid     <= 1'b0;
      bubble_count <= 8'd0;
    end else if (!hold) begin
      if (insert_bubble || !ID_valid) begin
        EX_rs    <= '0;
        EX_rt    <= '0;
        EX_rd    <= '0;
        EX_data1 <= '0;
        EX_data2 <= '0;
        EX_imm   <= '0;
        ex_ctrl  <= '0;
        EX_valid <= 1'b0;
      end else begin
        EX_rs    <= ID_rs;
        EX_rt    <= ID_rt;
        EX_rd    <= ID_rd;
        EX_data1 <= ID_data1;
        EX_data2 <= ID_data2;
        EX_imm   <= ID_imm;
        ex_ctrl  <= id_ctrl;
        EX_valid <= 1'b1;
      end
      // Empty-ID bubbles are not hazard bubbles and are not counted.
      if (insert_bubble && bubble_count != 8'hFF) begin
        bubble_count <= bubble_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed hazard scenarios plus random traffic against
// a cycle-level reference model of the stage contents and bubble counter.
module tb_id_ex_stage;

  typedef struct packed {
    logic [4:0] rs, rt, rd;
    logic [7:0] d1, d2, imm;
    logic       rw, mr, mw, m2r, as;
    logic [2:0] op;
    logic       v;
  } instr_t;

  logic clk = 1'b0;
  logic rst, flush, hold, uses_rt;
  instr_t id;

  logic [4:0] ex_rs, ex_rt, ex_rd;
  logic [7:0] ex_d1, ex_d2, ex_imm;
  logic       ex_rw, ex_mr, ex_mw, ex_m2r, ex_as, ex_v;
  logic [2:0] ex_op;
  logic       pc_write, ifid_write, lu;
  logic [7:0] bcnt;

  instr_t m_ex;
  int     m_cnt;
  int     vectors = 0;
  int     miscompares = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(8), .REG_W(5)) dut (
    .clk(clk), .rst(rst),
    .ID_rs(id.rs), .ID_rt(id.rt), .ID_rd(id.rd), .ID_uses_rt(uses_rt),
    .ID_data1(id.d1), .ID_data2(id.d2), .ID_imm(id.imm),
    .ID_RegWrite(id.rw), .ID_MemRead(id.mr), .ID_MemWrite(id.mw),
    .ID_MemToReg(id.m2r), .ID_ALUSrc(id.as), .ID_ALUOp(id.op), .ID_valid(id.v),
    .flush(flush), .hold(hold),
    .EX_rs(ex_rs), .EX_rt(ex_rt), .EX_rd(ex_rd),
    .EX_data1(ex_d1), .EX_data2(ex_d2), .EX_imm(ex_imm),
    .EX_RegWrite(ex_rw), .EX_MemRead(ex_mr), .EX_MemWrite(ex_mw),
    .EX_MemToReg(ex_m2r), .EX_ALUSrc(ex_as), .EX_ALUOp(ex_op), .EX_valid(ex_v),
    .PC_write(pc_write), .IFID_write(ifid_write), .load_use(lu),
    .bubble_count(bcnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic model_hazard();
    return m_ex.v && m_ex.mr && (m_ex.rt != 5'd31) && id.v &&
           ((m_ex.rt == id.rs) || (uses_rt && m_ex.rt == id.rt));
  endfunction

  // Inputs are applied at the falling edge; compare just after, then advance the model at the rising edge.
  task automatic step();
    logic   haz;
    logic   stall;
    instr_t nxt;
    int     ncnt;
    #1;
    haz   = model_hazard();
    stall = hold || (!flush && haz);
    check("load_use", {31'd0, lu}, {31'd0, haz});
    check("PC_write", {31'd0, pc_write}, {31'd0, !stall});
    check("IFID_write", {31'd0, ifid_write}, {31'd0, !stall});
    check("EX_rs", {27'd0, ex_rs}, {27'd0, m_ex.rs});
    check("EX_rt", {27'd0, ex_rt}, {27'd0, m_ex.rt});
    check("EX_rd", {27'd0, ex_rd}, {27'd0, m_ex.rd});
    check("EX_data", {8'd0, ex_d1, ex_d2, ex_imm}, {8'd0, m_ex.d1, m_ex.d2, m_ex.imm});
    check("EX_ctrl", {23'd0, ex_rw, ex_mr, ex_mw, ex_m2r, ex_as, ex_op, ex_v},
          {23'd0, m_ex.rw, m_ex.mr, m_ex.mw, m_ex.m2r, m_ex.as, m_ex.op, m_ex.v});
    check("bubble_count", {24'd0, bcnt}, m_cnt);
    nxt  = m_ex;
    ncnt = m_cnt;
    if (rst) begin
      nxt  = '0;
      ncnt = 0;
    end else if (!hold) begin
      if (flush || haz) begin
        nxt  = '0;
        ncnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
      end else begin
        nxt = id.v ? id : '0;
      end
    end
    @(posedge clk);
    m_ex  = nxt;
    m_cnt = ncnt;
    @(negedge clk);
  endtask

  task automatic rand_id();
    logic [4:0] regs [5];
    regs = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd31};
    id.rs  = regs[$urandom_range(0, 4)];
    id.rt  = regs[$urandom_range(0, 4)];
    id.rd  = 5'($urandom);
    id.d1  = 8'($urandom);
    id.d2  = 8'($urandom);
    id.imm = 8'($urandom);
    id.rw  = 1'($urandom);
    id.mr  = ($urandom_range(0, 2) == 0);
    id.mw  = 1'($urandom);
    id.m2r = 1'($urandom);
    id.as  = 1'($urandom);
    id.op  = 3'($urandom);
    id.v   = ($urandom_range(0, 5) != 0);
    uses_rt = 1'($urandom);
  endtask

  task automatic load_instr(input logic [4:0] rt);
    id = '0;
    id.v = 1'b1; id.mr = 1'b1; id.rw = 1'b1; id.m2r = 1'b1; id.as = 1'b1;
    id.rs = 5'd1; id.rt = rt; id.rd = rt;
    uses_rt = 1'b0;
  endtask

  task automatic alu_instr(input logic [4:0] rs, input logic [4:0] rt, input logic use_rt);
    id = '0;
    id.v = 1'b1; id.rw = 1'b1; id.rs = rs; id.rt = rt; id.rd = 5'd9;
    id.d1 = 8'h11; id.d2 = 8'h22; id.op = 3'd1;
    uses_rt = use_rt;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; hold = 1'b0; id = '0; uses_rt = 1'b0;
    m_ex = '0; m_cnt = 0;
    @(posedge clk);
    @(negedge clk);
    step();
    #1;
    check("rst_EX_valid", {31'd0, ex_v}, 32'd0);
    check("rst_bubble_count", {24'd0, bcnt}, 32'd0);
    check("rst_PC_write", {31'd0, pc_write}, 32'd1);
    rst = 1'b0;

    // Straight-line instruction
    id = '0; id.v = 1'b1; id.rs = 5'd2; id.d1 = 8'h3C; id.op = 3'd3;
    step();
    #1;
    check("sl_EX_rs", {27'd0, ex_rs}, 32'd2);
    check("sl_EX_data1", {24'd0, ex_d1}, 32'h3C);
    check("sl_EX_ALUOp", {29'd0, ex_op}, 32'd3);
    check("sl_PC_write", {31'd0, pc_write}, 32'd1);

    // Load-use on rs
    load_instr(5'd4);
    step();
    alu_instr(5'd4, 5'd7, 1'b0);
    #1;
    check("lu_load_use", {31'd0, lu}, 32'd1);
    check("lu_PC_write", {31'd0, pc_write}, 32'd0);
    check("lu_IFID_write", {31'd0, ifid_write}, 32'd0);
    step();
    #1;
    check("lu_bubble_valid", {31'd0, ex_v}, 32'd0);
    check("lu_bubble_count", {24'd0, bcnt}, 32'd1);
    check("lu_cleared", {31'd0, lu}, 32'd0);
    step();
    #1;
    check("lu_dep_in_EX", {26'd0, ex_v, ex_rs}, {26'd0, 1'b1, 5'd4});

    // rt match without uses_rt, and load into register 31
    load_instr(5'd5);
    step();
    alu_instr(5'd1, 5'd5, 1'b0);
    #1;
    check("no_uses_rt", {31'd0, lu}, 32'd0);
    step();
    load_instr(5'd31);
    step();
    alu_instr(5'd31, 5'd31, 1'b1);
    #1;
    check("rt31_no_stall", {31'd0, lu}, 32'd0);
    step();

    // Flush coinciding with load-use
    load_instr(5'd6);
    step();
    alu_instr(5'd6, 5'd2, 1'b1);
    flush = 1'b1;
    #1;
    check("flush_PC_write", {31'd0, pc_write}, 32'd1);
    step();
    flush = 1'b0;
    #1;
    check("flush_bubble", {31'd0, ex_v}, 32'd0);
    check("flush_count_once", {24'd0, bcnt}, 32'd2);

    // Hold during a hazard, then release
    load_instr(5'd3);
    step();
    alu_instr(5'd3, 5'd1, 1'b0);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) step();
    #1;
    check("hold_frozen_rt", {26'd0, ex_mr, ex_rt}, {26'd0, 1'b1, 5'd3});
    check("hold_count", {24'd0, bcnt}, 32'd2);
    hold = 1'b0;
    step();
    #1;
    check("hold_release_bubble", {31'd0, ex_v}, 32'd0);
    check("hold_release_count", {24'd0, bcnt}, 32'd3);
    step();

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      rand_id();
      flush = ($urandom_range(0, 9) == 0);
      hold  = ($urandom_range(0, 7) == 0);
      rst   = ($urandom_range(0, 49) == 0);
      step();
    end
    rst = 1'b0; flush = 1'b0; hold = 1'b0;

    // Counter saturation, then reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    flush = 1'b1;
    for (int i = 0; i < 300; i++) begin
      rand_id();
      step();
    end
    flush = 1'b0;
    #1;
    check("sat_255", {24'd0, bcnt}, 32'd255);
    rst = 1'b1;
    step();
    rst = 1'b0;
    id = '0;
    #1;
    check("post_rst_count", {24'd0, bcnt}, 32'd0);
    check("post_rst_ctrl", {24'd0, ex_rw, ex_mr, ex_mw, ex_m2r, ex_as, ex_op}, 32'd0);
    check("post_rst_regs", {17'd0, ex_rs, ex_rt, ex_rd}, 32'd0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
